// File: rtl/seg7_scan_mux.sv
// Scans NDIG active-low segment bytes onto one shared bus, one anode at a time, with PWM dimming,
// a blanked guard interval at the start of each slot and a frame strobe. Define BLINK_EN to add per-digit blinking.
module seg7_scan_mux #(
  parameter int NDIG  = 4,
  parameter int DIV   = 50000,
  parameter int GUARD = 16,
  parameter int BR_W  = 3
`ifdef BLINK_EN
  , parameter int BLINK_FR = 64
`endif
) (
  input  logic              clk,
  input  logic              rst_asyn,
  input  logic [8*NDIG-1:0] Seg_in,
  input  logic [NDIG-1:0]   Dig_en,
  input  logic [BR_W-1:0]   Bright,
`ifdef BLINK_EN
  input  logic [NDIG-1:0]   Blink,
`endif
  output logic [7:0]        Seg_out,
  output logic [NDIG-1:0]   An_out,
  output logic              Frame_out
);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);

  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [BR_W-1:0]  pwm;
  logic             tick;
  logic             frame_wrap;
  logic             guard_ok;
  logic             drive;
  logic [7:0]       seg_sel;
  logic [NDIG-1:0]  an_sel;
  logic             en_sel;
  logic             blink_mask;

  assign tick       = (cnt == CNT_LAST);
  assign frame_wrap = tick && (idx == IDX_LAST);

  // A zero guard would make the compare constant, so it is elaborated away.
  generate
    if (GUARD == 0) begin : g_no_guard
      assign guard_ok = 1'b1;
    end else begin : g_guard
      assign guard_ok = (cnt >= CNT_W'(GUARD));
    end
  endgenerate

`ifdef BLINK_EN
  localparam int FR_W = (BLINK_FR > 1) ? $clog2(BLINK_FR) : 1;
  localparam logic [FR_W-1:0] FR_LAST = FR_W'(BLINK_FR - 1);

  logic [FR_W-1:0] fr_cnt;
  logic            phase;
  logic            blink_sel;
`endif

  always_comb begin
    seg_sel = 8'hFF;
    an_sel  = '1;
    en_sel  = 1'b0;
`ifdef BLINK_EN
    blink_sel = 1'b0;
`endif
    for (int d = 0; d < NDIG; d++) begin
      if (idx == IDX_W'(d)) begin
        seg_sel   = Seg_in[8*d +: 8];
        an_sel[d] = 1'b0;
        en_sel    = Dig_en[d];
`ifdef BLINK_EN
        blink_sel = Blink[d];
`endif
      end
    end
  end

`ifdef BLINK_EN
  // Phase flips on the frame wrap itself, so it lines up with the frame boundary.
  always_ff @(posedge clk or negedge rst_asyn) begin
    if (!rst_asyn) begin
      fr_cnt <= '0;
      phase  <= 1'b0;
    end else if (frame_wrap) begin
      if (fr_cnt == FR_LAST) begin
        fr_cnt <= '0;
        phase  <= ~phase;
      end else begin
        fr_cnt <= fr_cnt + FR_W'(1);
      end
    end
  end

  assign blink_mask = phase && blink_sel;
`else
  assign blink_mask = 1'b0;
`endif

  assign drive = guard_ok && (pwm <= Bright) && en_sel && !blink_mask;

  always_ff @(posedge clk or negedge rst_asyn) begin
    if (!rst_asyn) begin
      cnt <= '0;
      idx <= '0;
      pwm <= '0;
    end else begin
      pwm <= pwm + BR_W'(1);
      if (tick) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_asyn) begin
    if (!rst_asyn) begin
      Seg_out   <= 8'hFF;
      An_out    <= '1;
      Frame_out <= 1'b0;
    end else begin
      Seg_out   <= drive ? seg_sel : 8'hFF;
      An_out    <= drive ? an_sel : '1;
      Frame_out <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Scoreboard bench for seg7_scan_mux: expectations derived from elapsed cycles since reset release.
module tb_seg7_scan_mux;
  localparam int NDIG  = 4;
  localparam int DIV   = 8;
  localparam int GUARD = 1;
  localparam int BR_W  = 2;
  localparam int FRAME = DIV * NDIG;
  localparam logic [31:0] SCAN = 32'hB0A4F9C0;

  logic        clk;
  logic        rst_asyn;
  logic [31:0] Seg_in;
  logic [3:0]  Dig_en;
  logic [1:0]  Bright;
  logic [7:0]  Seg_out;
  logic [3:0]  An_out;
  logic        Frame_out;

  typedef struct {
    int         t;
    logic [3:0] an;
    logic [7:0] seg;
    logic       frame;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   t = 0;

  seg7_scan_mux #(.NDIG(NDIG), .DIV(DIV), .GUARD(GUARD), .BR_W(BR_W)) dut (
    .clk(clk), .rst_asyn(rst_asyn), .Seg_in(Seg_in), .Dig_en(Dig_en), .Bright(Bright),
    .Seg_out(Seg_out), .An_out(An_out), .Frame_out(Frame_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected outputs after the clock edge that consumes cycle tt since release.
  function automatic exp_t model(input int tt, input logic [31:0] s, input logic [3:0] e,
                                 input logic [1:0] b);
    exp_t r;
    int slot  = tt % DIV;
    int digit = (tt / DIV) % NDIG;
    int level = tt % (1 << BR_W);
    r.t     = tt;
    r.frame = ((tt % FRAME) == FRAME - 1);
    r.an    = 4'hF;
    r.seg   = 8'hFF;
    if (slot >= GUARD && level <= int'(b) && e[digit]) begin
      r.an[digit] = 1'b0;
      r.seg       = s[8*digit +: 8];
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step(input logic [31:0] s, input logic [3:0] e, input logic [1:0] b);
    Seg_in = s;
    Dig_en = e;
    Bright = b;
    sb.push_back(model(t, s, e, b));
    t++;
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk($sformatf("an t=%0d", x.t), 32'(An_out), 32'(x.an));
        chk($sformatf("seg t=%0d", x.t), 32'(Seg_out), 32'(x.seg));
        chk($sformatf("frame t=%0d", x.t), 32'(Frame_out), 32'(x.frame));
      end
      chk("an_one_low", 32'($countones(~An_out) <= 1), 32'd1);
      if (An_out == 4'hF) chk("seg_blank_when_idle", 32'(Seg_out), 32'hFF);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] s;
    logic [3:0]  e;
    logic [1:0]  b;
    int          wait_cnt;
    Seg_in   = '1;
    Dig_en   = '0;
    Bright   = '0;
    rst_asyn = 1'b1;
    #1 rst_asyn = 1'b0;
    #12;
    chk("reset_an", 32'(An_out), 32'hF);
    chk("reset_seg", 32'(Seg_out), 32'hFF);
    chk("reset_frame", 32'(Frame_out), 32'd0);

    @(negedge clk);
    rst_asyn = 1'b1;
    for (int i = 0; i < 18; i++) step(SCAN, 4'hF, 2'd3);

    // Asynchronous reset in the middle of digit 2's slot.
    @(posedge clk);
    #3;
    chk("pre_reset_an", 32'(An_out), 32'b1011);
    rst_asyn = 1'b0;
    #1;
    chk("async_reset_an", 32'(An_out), 32'hF);
    chk("async_reset_seg", 32'(Seg_out), 32'hFF);
    chk("async_reset_frame", 32'(Frame_out), 32'd0);
    chk("sb_empty_at_reset", 32'(sb.size()), 32'd0);
    t = 0;
    repeat (2) @(negedge clk);
    rst_asyn = 1'b1;

    for (int i = 0; i < 64; i++) step(SCAN, 4'hF, 2'd3);
    for (int i = 0; i < 40; i++) step(SCAN, 4'hF, 2'd0);
    for (int i = 0; i < 40; i++) step(SCAN, 4'hF, 2'd1);
    for (int i = 0; i < 40; i++) step(SCAN, 4'b0101, 2'd3);
    for (int i = 0; i < 64; i++) step(SCAN, 4'h0, 2'd3);

    s = $urandom;
    e = 4'($urandom_range(0, 15));
    b = 2'($urandom_range(0, 3));
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        s = $urandom;
        e = 4'($urandom_range(0, 15));
        b = 2'($urandom_range(0, 3));
      end
      step(s, e, b);
    end

    wait_cnt = 0;
    while (sb.size() > 0 && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
